aes128_iter_ctrl: RTL

Iterative AES-128 encryption controller: accepts one plaintext block and key through a valid/ready handshake. Executes the initial AddRoundKey and 10 rounds on a single shared combinational round/key-expansion datapath, one round per clock. Presents ciphertext and final round key through a second valid/ready handshake. Replaces the 10-instance unrolled core where area matters; sits between the host block interface and downstream consumers.

---
 rtl/aes_pkg.sv | 60 ++++++
 rtl/aes128_iter_ctrl_if.sv | 24 ++
 rtl/aes_round_comb.sv | 56 +++++
 rtl/aes128_iter_ctrl.sv | 103 ++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 types, constants and byte-level helpers
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [3:0] AES_ROUNDS = 4'd10;

  // Forward S-box, entry 0x00 in the most significant byte
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [2047:0] shifted;
    shifted = SBOX_TABLE << {b, 3'b000};
    return shifted[2047:2040];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] rcon(input logic [3:0] rnd);
    logic [7:0] rc;
    case (rnd)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return {rc, 24'h000000};
  endfunction

endpackage

// File: rtl/aes128_iter_ctrl_if.sv
// rtl/aes128_iter_ctrl_if.sv - block-in / result-out handshake bundle of the iterative AES controller
interface aes128_iter_ctrl_if;

  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [127:0] out_key;
  logic         busy;

  modport master (
    output in_valid, in_data, in_key, out_ready,
    input  in_ready, out_valid, out_data, out_key, busy
  );

  modport slave (
    input  in_valid, in_data, in_key, out_ready,
    output in_ready, out_valid, out_data, out_key, busy
  );

endinterface

// File: rtl/aes_round_comb.sv
// rtl/aes_round_comb.sv - one AES-128 round plus the matching key-expansion step, purely combinational
module aes_round_comb
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] key,
  input  logic [31:0]  rcon_word,
  input  logic         last,
  output logic [127:0] next_state,
  output logic [127:0] next_key
);

  logic [31:0] w0, w1, w2, w3, temp;
  logic [31:0] nw0, nw1, nw2, nw3;
  logic [7:0]  sb [16];
  logic [7:0]  sr [16];
  logic [7:0]  mc [16];

  always_comb begin
    w0   = key[127:96];
    w1   = key[95:64];
    w2   = key[63:32];
    w3   = key[31:0];
    // RotWord folded into the byte order of the SubWord lookups
    temp = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ rcon_word;
    nw0  = w0 ^ temp;
    nw1  = w1 ^ nw0;
    nw2  = w2 ^ nw1;
    nw3  = w3 ^ nw2;
  end

  assign next_key = {nw0, nw1, nw2, nw3};

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      sb[i] = sbox(state[127-8*i -: 8]);
    end
    // Byte 4c+r is row r of column c; row r rotates left by r columns
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[4*c+r] = sb[4*((c+r)%4)+r];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mc[4*c]   = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
      mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
    end
    next_state = '0;
    for (int i = 0; i < 16; i++) begin
      next_state[127-8*i -: 8] = (last ? sr[i] : mc[i]) ^ next_key[127-8*i -: 8];
    end
  end

endmodule

// File: rtl/aes128_iter_ctrl.sv
// rtl/aes128_iter_ctrl.sv - iterative AES-128 encryptor: one round per clock on a shared round datapath
module aes128_iter_ctrl
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  aes128_iter_ctrl_if.slave  bus
);

  state_e       state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] data_q, data_d;
  logic [127:0] key_q, key_d;
  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;
  logic         busy_q, busy_d;

  logic [127:0] round_state, round_key;
  logic [31:0]  rcon_word;
  logic         last_round;
  logic         rnd_legal;

  assign rcon_word  = rcon(rnd_q);
  assign last_round = (rnd_q == AES_ROUNDS);
  assign rnd_legal  = (rnd_q >= 4'd1) && (rnd_q <= AES_ROUNDS);

  aes_round_comb u_round (
    .state      (data_q),
    .key        (key_q),
    .rcon_word  (rcon_word),
    .last       (last_round),
    .next_state (round_state),
    .next_key   (round_key)
  );

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    data_d  = data_q;
    key_d   = key_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          data_d  = bus.in_data ^ bus.in_key;
          key_d   = bus.in_key;
          rnd_d   = 4'd1;
          state_d = ROUND;
        end
      end
      ROUND: begin
        // A corrupted round counter ends the block rather than running on
        if (!rnd_legal) begin
          state_d = DONE;
        end else begin
          data_d = round_state;
          key_d  = round_key;
          if (last_round) begin
            state_d = DONE;
          end else begin
            rnd_d = rnd_q + 4'd1;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
          rnd_d   = 4'd0;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d == ROUND);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rnd_q       <= 4'd0;
      data_q      <= '0;
      key_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rnd_q       <= rnd_d;
      data_q      <= data_d;
      key_q       <= key_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.out_data  = data_q;
  assign bus.out_key   = key_q;

endmodule
